// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU control path: opcodes, sequencer states,
// ALU operation codes and instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC1,
        S_EXEC2,
        S_HALT
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;
    localparam int RD_HI  = 3;
    localparam int RD_LO  = 2;
    localparam int RS_HI  = 1;
    localparam int RS_LO  = 0;

    function automatic logic is_alu_op(input logic [3:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    endfunction

    function automatic logic [2:0] alu_encode(input logic [3:0] opc);
        logic [2:0] op;
        op = ALU_ADD;
        case (opc)
            OP_SUB:  op = ALU_SUB;
            OP_AND:  op = ALU_AND;
            OP_OR:   op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: loads RESET_PC on reset, advances by one (modulo
// 2^PC_WIDTH) when inc is high.
module program_counter #(
    parameter int                    PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else if (inc) begin
            pc_reg <= pc_reg + PC_WIDTH'(1);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC and instruction register and
// drives the register file, memory read and ALU controls as Moore outputs.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          in_databus,
    output logic [PC_WIDTH-1:0] pc_addr,
    output logic                mem_read,
    output logic                load,
    output logic                enable,
    output logic [1:0]          in_regselect,
    output logic [1:0]          out_regselect,
    output logic [1:0]          alu_regselect,
    output logic [2:0]          alu_op,
    output logic                alu_latch,
    output logic                alu_out_enable,
    output logic                halted
);

    state_t     state_reg;
    logic [7:0] ir_reg;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       pc_inc;

    assign opcode = ir_reg[OPC_HI:OPC_LO];
    assign rd     = ir_reg[RD_HI:RD_LO];
    assign rs     = ir_reg[RS_HI:RS_LO];

    // The PC advances past the opcode byte and, for LDI, past the immediate.
    assign pc_inc = (state_reg == S_FETCH) ||
                    ((state_reg == S_EXEC1) && (opcode == OP_LDI));

    program_counter #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .clock (clock),
        .reset (reset),
        .inc   (pc_inc),
        .pc    (pc_addr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
            ir_reg    <= 8'h00;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    ir_reg    <= in_databus;
                    state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    if (opcode == OP_HLT)
                        state_reg <= S_HALT;
                    else if ((opcode >= OP_MOV) && (opcode <= OP_LDI))
                        state_reg <= S_EXEC1;
                    else
                        state_reg <= S_FETCH;
                end
                S_EXEC1: state_reg <= is_alu_op(opcode) ? S_EXEC2 : S_FETCH;
                S_EXEC2: state_reg <= S_FETCH;
                S_HALT:  state_reg <= S_HALT;
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    // Outputs are forced low while reset is held so the bus is released at once.
    always_comb begin
        mem_read       = 1'b0;
        load           = 1'b0;
        enable         = 1'b0;
        in_regselect   = 2'd0;
        out_regselect  = 2'd0;
        alu_regselect  = 2'd0;
        alu_op         = ALU_ADD;
        alu_latch      = 1'b0;
        alu_out_enable = 1'b0;
        halted         = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_FETCH: mem_read = 1'b1;
                S_EXEC1: begin
                    if (opcode == OP_MOV) begin
                        enable        = 1'b1;
                        out_regselect = rs;
                        load          = 1'b1;
                        in_regselect  = rd;
                    end else if (opcode == OP_LDI) begin
                        mem_read     = 1'b1;
                        load         = 1'b1;
                        in_regselect = rd;
                    end else if (is_alu_op(opcode)) begin
                        enable        = 1'b1;
                        out_regselect = rs;
                        alu_regselect = rd;
                        alu_op        = alu_encode(opcode);
                        alu_latch     = 1'b1;
                    end
                end
                S_EXEC2: begin
                    alu_out_enable = 1'b1;
                    load           = 1'b1;
                    in_regselect   = rd;
                    alu_op         = alu_encode(opcode);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
